bcd_serial_addsub: RTL and testbench
====================================

BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits per operand (legal range 1..16).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request a new operation; accepted only while ready=1.
REQ-005 op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 cin  input  1  add: decimal carry-in; sub: borrow-in; sampled with start.
REQ-007 a, b  input  4*DIGITS  packed BCD operands, digit 0 in bits [3:0]; sampled with start.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  4*DIGITS  packed BCD result.
REQ-011 cout  output  1  add: decimal carry-out; sub: 1 = no borrow (result non-negative).
REQ-012 invalid  output  1  some operand digit was >9 in the latched operation.

Function
REQ-013 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after DIGITS digit cycles; DONE->IDLE unconditionally.
REQ-014 Start accepted at edge T: a, b, op_sub, cin latched into internal registers; digit index cleared; carry register loaded with cin (add) or ~cin (sub).
REQ-015 RUN processes one digit per cycle, LSB first; digit i is processed at edge T+1+i.
REQ-016 Digit rule: t = a_i + b'_i + carry (5-bit binary); b'_i = b_i (add) or 9-b_i (sub); if t>9 then digit = (t+6) mod 16 and carry=1, else digit = t and carry=0.
REQ-017 done=1 for exactly the cycle in DONE (after edge T+DIGITS); start-to-done latency = DIGITS+1 edges.
REQ-018 cout = final carry register; sum written digit-by-digit and held stable from DONE until the next accepted start.
REQ-019 invalid computed from latched operands at acceptance (any a_i>9 or b_i>9); result still produced by REQ-016; held until next start.
REQ-020 start while ready=0 is ignored; operands changing after acceptance do not affect the result.
REQ-021 start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted (minimum back-to-back spacing DIGITS+2 edges).
REQ-022 Subtraction wrap-around: a<b yields ten's-complement result with cout=0 (e.g. 0000-0001 = 9999).

Reset
REQ-023 rst_n=0 at a clock edge forces IDLE; sum=0, cout=0, done=0, invalid=0, internal digit index and carry cleared; ready=1 from the first cycle after reset.
REQ-024 Reset during RUN or DONE aborts the operation with no done pulse; reset overrides a simultaneous start.

Structure
REQ-025 Shared package bcd_pkg: BCD_W=4 constant, bcd_digit_t type, FSM state enum (IDLE, RUN, DONE).
REQ-026 One sub-module bcd_digit_add: combinational single-digit add with +6 correction, inputs a, b, cin, outputs s, cout; the top instantiates it once and reuses it across cycles.
REQ-027 No latches; all registers reset per REQ-023; ready and done derived from the state register only.

Verification (DIGITS=4)
REQ-028 add 0999+0001, cin=0 -> done at 5th edge after start, sum=1000, cout=0, invalid=0.
REQ-029 add 9999+0001, cin=0 -> sum=0000, cout=1; add 4567+5433, cin=1 -> sum=0001, cout=1.
REQ-030 sub 0100-0001, cin=0 -> sum=0099, cout=1; sub 0000-0001, cin=0 -> sum=9999, cout=0.
REQ-031 add 00A2+0001 -> invalid=1, sum per REQ-016 digit rule; next valid operation clears invalid.
REQ-032 start pulsed mid-RUN with different operands -> ignored, original result returned; start in DONE cycle ignored.
REQ-033 rst_n=0 two cycles into RUN -> no done, sum=0, ready=1 after reset; a new operation then completes correctly.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared constants and types for the serial BCD adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Width of one packed BCD digit
    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // Sequencer states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_add
// Brief    : Combinational single-digit decimal adder with +6 correction.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout
);

    logic [BCD_W:0] w_t;

    // Binary sum, then fold anything above 9 back into decimal range
    always_comb begin
        w_t  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        s    = w_t[BCD_W-1:0];
        cout = 1'b0;
        if (w_t > 5'd9) begin
            s    = w_t[BCD_W-1:0] + 4'd6;
            cout = 1'b1;
        end
    end

endmodule : bcd_digit_add
`default_nettype wire

// File: rtl/bcd_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_addsub
// Brief    : Digit-serial packed-BCD add/subtract, one digit per clock,
//            LSB first, using a single shared digit adder.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid
);

    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             op_q, op_d;
    logic             carry_q, carry_d;
    logic             inv_q, inv_d;

    bcd_digit_t       w_dig_a;
    bcd_digit_t       w_dig_b;
    bcd_digit_t       w_dig_s;
    logic             w_dig_c;
    logic [DIGITS-1:0] w_bad;

    // Flag any non-decimal digit on the incoming operands
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
        assign w_bad[gi] = (a[gi*BCD_W +: BCD_W] > 4'd9) ||
                           (b[gi*BCD_W +: BCD_W] > 4'd9);
    end

    // Operand registers are shifted right, so digit 0 is always the current one;
    // subtraction uses the nine's complement of b with the inverted borrow as carry.
    always_comb begin
        w_dig_a = a_q[BCD_W-1:0];
        w_dig_b = op_q ? (4'd9 - b_q[BCD_W-1:0]) : b_q[BCD_W-1:0];
    end

    bcd_digit_add u_digit (
        .a    (w_dig_a),
        .b    (w_dig_b),
        .cin  (carry_q),
        .s    (w_dig_s),
        .cout (w_dig_c)
    );

    // Next-state and datapath updates for the three-state sequencer
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        op_d    = op_q;
        carry_d = carry_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_sub;
                    carry_d = op_sub ? ~cin : cin;
                    idx_d   = '0;
                    inv_d   = |w_bad;
                end
            end
            RUN: begin
                a_d     = a_q >> BCD_W;
                b_d     = b_q >> BCD_W;
                // New digit enters at the top; after DIGITS shifts digit 0 sits at [3:0]
                sum_d   = (sum_q >> BCD_W) | (W'(w_dig_s) << (W - BCD_W));
                carry_d = w_dig_c;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            inv_q   <= inv_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = carry_q;
    assign invalid = inv_q;

endmodule : bcd_serial_addsub
`default_nettype wire

// File: tb/tb_bcd_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_serial_addsub
// Brief    : Scoreboard bench: stimulus pushes expected results, a monitor
//            pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         inv;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_err;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_sub  (op_sub),
        .cin     (cin),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checks
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        longint p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r += longint'(v[i*4 +: 4]) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sub, input logic ci);
        exp_t   e;
        longint lim = 1;
        longint r;
        int     c;
        int     t;
        int     bd;
        for (int i = 0; i < DIGITS; i++) lim *= 10;
        e.inv = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (av[i*4 +: 4] > 9 || bv[i*4 +: 4] > 9) e.inv = 1'b1;
        if (!e.inv) begin
            // Plain decimal arithmetic on well-formed operands
            if (sub) begin
                r      = bcd2int(av) - bcd2int(bv) - longint'(ci);
                e.cout = (r >= 0);
                if (r < 0) r += lim;
            end else begin
                r      = bcd2int(av) + bcd2int(bv) + longint'(ci);
                e.cout = (r >= lim);
                if (r >= lim) r -= lim;
            end
            e.sum = int2bcd(r);
        end else begin
            // Malformed digits: apply the stated per-digit correction rule
            c = sub ? (ci ? 0 : 1) : (ci ? 1 : 0);
            for (int i = 0; i < DIGITS; i++) begin
                bd = sub ? (9 - int'(bv[i*4 +: 4])) : int'(bv[i*4 +: 4]);
                t  = int'(av[i*4 +: 4]) + bd + c;
                if (t > 9) begin
                    e.sum[i*4 +: 4] = 4'((t + 6) % 16);
                    c = 1;
                end else begin
                    e.sum[i*4 +: 4] = 4'(t);
                    c = 0;
                end
            end
            e.cout = c[0];
        end
        return e;
    endfunction

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: sum %h with empty scoreboard at %0t", sum, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum",     sum,         e.sum);
                check("cout",    W'(cout),    W'(e.cout));
                check("invalid", W'(invalid), W'(e.inv));
            end
        end
    end

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Issue one operation starting just after a rising edge with the DUT idle.
    // inject: 0 none, 1 stray start mid-RUN, 2 stray start in the DONE cycle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sub, input logic ci, input exp_t e, input int inject);
        a = av; b = bv; op_sub = sub; cin = ci; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a = rand_bcd(); b = rand_bcd(); op_sub = ~sub; cin = ~ci;
        check("busy_after_accept", W'(ready), W'(1'b0));
        for (int k = 1; k < DIGITS; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (inject == 1 && k == 2) begin
                start = 1'b1; a = rand_bcd(); b = rand_bcd();
            end
            if (k == DIGITS - 1) check("no_early_done", W'(done), W'(1'b0));
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("done_latency", W'(done), W'(1'b1));
        if (inject == 2) begin
            start = 1'b1; a = rand_bcd(); b = rand_bcd();
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("ready_after_done", W'(ready), W'(1'b1));
        if (inject == 2) begin
            @(posedge clk); #1;
            check("done_cycle_start_ignored", W'(ready), W'(1'b1));
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic i);
        exp_t e;
        e.sum = s; e.cout = c; e.inv = i;
        return e;
    endfunction

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic         rc;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; cin = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",   W'(ready),   W'(1'b1));
        check("rst_done",    W'(done),    W'(1'b0));
        check("rst_sum",     sum,         '0);
        check("rst_cout",    W'(cout),    W'(1'b0));
        check("rst_invalid", W'(invalid), W'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-derived results
        run_op(16'h0999, 16'h0001, 1'b0, 1'b0, mk(16'h1000, 1'b0, 1'b0), 0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), 0);
        run_op(16'h4567, 16'h5433, 1'b0, 1'b1, mk(16'h0001, 1'b1, 1'b0), 0);
        run_op(16'h0100, 16'h0001, 1'b1, 1'b0, mk(16'h0099, 1'b1, 1'b0), 0);
        run_op(16'h0000, 16'h0001, 1'b1, 1'b0, mk(16'h9999, 1'b0, 1'b0), 0);
        run_op(16'h00A2, 16'h0001, 1'b0, 1'b0, mk(16'h0103, 1'b0, 1'b1), 0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0), 1);
        run_op(16'h5000, 16'h2500, 1'b1, 1'b1, mk(16'h2499, 1'b1, 1'b0), 2);

        // Reset two cycles into RUN aborts the operation
        a = 16'h1111; b = 16'h2222; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        check("abort_done",  W'(done),  W'(1'b0));
        check("abort_sum",   sum,       '0);
        check("abort_ready", W'(ready), W'(1'b1));
        check("abort_cout",  W'(cout),  W'(1'b0));
        repeat (DIGITS + 2) @(posedge clk);
        #1;
        run_op(16'h0042, 16'h0058, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0), 0);

        // Randomized operations against the reference model
        for (int n = 0; n < 60; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) ra[$urandom_range(0, DIGITS-1)*4 +: 4] = 4'($urandom_range(10, 15));
            run_op(ra, rb, rs, rc, model(ra, rb, rs, rc), int'($urandom_range(0, 2)));
        end

        repeat (DIGITS + 3) @(posedge clk);
        #1;
        check("scoreboard_drained", W'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bcd_serial_addsub
`default_nettype wire
